c7bbiu_rd_arb: RTL

//  Read-request arbiter of the BIU, directly upstream of the AXI interface stage.

---
 rtl/c7bbiu_rd_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/c7bbiu_rd_arb.sv
// c7bbiu_rd_arb: BIU read-request arbiter.
// Round-robin between IFU, LSU and ICU read requests. The winner's request is
// registered onto arb_rd_* and held until the AXI interface stage accepts it.
// One read may be outstanding per source. A source's busy bit drops on the last
// R beat carrying its ID.
module c7bbiu_rd_arb #(
  parameter logic [3:0]  ID_IFU    = 4'd0,
  parameter logic [3:0]  ID_LSU    = 4'd1,
  parameter logic [3:0]  ID_ICU    = 4'd2,
  parameter logic [7:0]  ICU_LEN   = 8'd3,
  parameter int unsigned ICU_ALIGN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  output logic        biu_ifu_rd_ack,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  input  logic [2:0]  lsu_biu_rd_size,
  output logic        biu_lsu_rd_ack,
  input  logic        icu_biu_rd_req,
  input  logic [31:0] icu_biu_rd_addr,
  output logic        biu_icu_rd_ack,
  input  logic        axi_ar_ready,
  input  logic        ext_biu_r_valid,
  input  logic [3:0]  ext_biu_r_id,
  input  logic        ext_biu_r_last,
  output logic        arb_rd_val,
  output logic [3:0]  arb_rd_id,
  output logic [31:0] arb_rd_addr,
  output logic [7:0]  arb_rd_len,
  output logic [2:0]  arb_rd_size,
  output logic [1:0]  arb_rd_burst,
  output logic        arb_rd_lock,
  output logic [3:0]  arb_rd_cache,
  output logic [2:0]  arb_rd_prot,
  output logic [2:0]  rd_busy
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;
  typedef enum logic [1:0] {SRC_IFU = 2'd0, SRC_LSU = 2'd1, SRC_ICU = 2'd2} src_t;

  localparam logic [31:0] ICU_MASK = ~((32'd1 << ICU_ALIGN) - 32'd1);

  state_t      r_state;
  src_t        r_ptr;
  src_t        r_src;
  logic        r_val;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [2:0]  r_prot;
  logic [2:0]  r_busy;

  logic [2:0]  w_elig;
  logic        w_gnt_vld;
  src_t        w_gnt_src;
  logic [2:0]  w_set;
  logic [2:0]  w_clr;
  logic        w_xfer;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [2:0]  w_prot;

  assign w_elig = {icu_biu_rd_req, lsu_biu_rd_req, ifu_biu_rd_req} & ~r_busy;
  assign w_xfer = r_val & axi_ar_ready;

  // Round-robin pick: first eligible source after the pointer in IFU->LSU->ICU order
  always_comb begin
    w_gnt_vld = |w_elig;
    w_gnt_src = SRC_IFU;
    case (r_ptr)
      SRC_IFU: begin
        if (w_elig[1])      w_gnt_src = SRC_LSU;
        else if (w_elig[2]) w_gnt_src = SRC_ICU;
        else                w_gnt_src = SRC_IFU;
      end
      SRC_LSU: begin
        if (w_elig[2])      w_gnt_src = SRC_ICU;
        else if (w_elig[0]) w_gnt_src = SRC_IFU;
        else                w_gnt_src = SRC_LSU;
      end
      default: begin
        if (w_elig[0])      w_gnt_src = SRC_IFU;
        else if (w_elig[1]) w_gnt_src = SRC_LSU;
        else                w_gnt_src = SRC_ICU;
      end
    endcase
  end

  // Request fields of the selected source
  always_comb begin
    w_id   = ID_IFU;
    w_addr = ifu_biu_rd_addr;
    w_len  = 8'd0;
    w_size = 3'b010;
    w_prot = 3'b100;
    case (w_gnt_src)
      SRC_LSU: begin
        w_id   = ID_LSU;
        w_addr = lsu_biu_rd_addr;
        w_size = lsu_biu_rd_size;
        w_prot = 3'b000;
      end
      SRC_ICU: begin
        w_id   = ID_ICU;
        w_addr = icu_biu_rd_addr & ICU_MASK;
        w_len  = ICU_LEN;
        w_size = 3'b011;
      end
      default: ;
    endcase
  end

  // Busy set on grant, clear on the matching last R beat
  always_comb begin
    w_set = '0;
    if (r_state == ST_IDLE && w_gnt_vld) w_set[w_gnt_src] = 1'b1;
    w_clr[0] = ext_biu_r_valid & ext_biu_r_last & (ext_biu_r_id == ID_IFU);
    w_clr[1] = ext_biu_r_valid & ext_biu_r_last & (ext_biu_r_id == ID_LSU);
    w_clr[2] = ext_biu_r_valid & ext_biu_r_last & (ext_biu_r_id == ID_ICU);
  end

  // Outstanding-read flags, one per source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr) | w_set;
  end

  // Arbitration FSM with registered request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= SRC_ICU;
      r_src   <= SRC_IFU;
      r_val   <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_prot  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_state <= ST_ISSUE;
            r_val   <= 1'b1;
            r_src   <= w_gnt_src;
            r_ptr   <= w_gnt_src;
            r_id    <= w_id;
            r_addr  <= w_addr;
            r_len   <= w_len;
            r_size  <= w_size;
            r_burst <= 2'b01;
            r_prot  <= w_prot;
          end
        end
        default: begin
          if (axi_ar_ready) begin
            r_state <= ST_IDLE;
            r_val   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign biu_ifu_rd_ack = w_xfer & (r_src == SRC_IFU);
  assign biu_lsu_rd_ack = w_xfer & (r_src == SRC_LSU);
  assign biu_icu_rd_ack = w_xfer & (r_src == SRC_ICU);

  assign arb_rd_val   = r_val;
  assign arb_rd_id    = r_id;
  assign arb_rd_addr  = r_addr;
  assign arb_rd_len   = r_len;
  assign arb_rd_size  = r_size;
  assign arb_rd_burst = r_burst;
  assign arb_rd_lock  = 1'b0;
  assign arb_rd_cache = 4'b0000;
  assign arb_rd_prot  = r_prot;
  assign rd_busy      = r_busy;

endmodule
